// File: rtl/sum_it_up.sv
// rtl/sum_it_up.sv - start-triggered accumulator that sums inA until a zero arrives
// done is a Mealy strobe on the terminating zero; sum is a register output.
module sum_it_up #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             reset_l,
  input  logic             go_l,
  input  logic [WIDTH-1:0] inA,
  output logic             done,
  output logic [WIDTH-1:0] sum
);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             in_zero;

  assign in_zero = (inA == '0);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        // The inA value presented alongside go_l is not part of the sequence.
        if (!go_l) begin
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (in_zero) begin
          state_d = IDLE;
        end else begin
          sum_d = sum_q + inA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!reset_l) begin
      state_q <= IDLE;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

  // Gated with reset_l so a zero arriving alongside a mid-sequence reset never strobes.
  assign done = reset_l && (state_q == ADD) && in_zero;
  assign sum  = sum_q;

endmodule

// File: tb/tb_sum_it_up.sv
// tb/tb_sum_it_up.sv - self-checking bench for sum_it_up against a sequence-level model
module tb_sum_it_up;

  logic       ck = 1'b0;
  logic       reset_l = 1'b0;
  logic       go_l = 1'b1;
  logic [7:0] inA = 8'd0;
  logic       done;
  logic [7:0] sum;
  logic [7:0] cap_q = 8'd0;

  int vectors = 0;
  int miscompares = 0;

  // Reference: whether a sequence is open and its running total as a plain integer.
  bit m_busy = 1'b0;
  int m_total = 0;

  sum_it_up #(.WIDTH(8)) dut (
    .ck     (ck),
    .reset_l(reset_l),
    .go_l   (go_l),
    .inA    (inA),
    .done   (done),
    .sum    (sum)
  );

  always #5 ck = ~ck;

  always @(posedge ck) if (done) cap_q <= sum;

  task automatic drive(input logic r, input logic g, input logic [7:0] a,
                       output logic ed, output logic [7:0] es);
    @(negedge ck);
    reset_l = r;
    go_l    = g;
    inA     = a;
    #1;
    ed = r && m_busy && (a == 8'd0);
    es = 8'(m_total % 256);
    if (!r) begin
      m_busy  = 1'b0;
      m_total = 0;
    end else if (!m_busy) begin
      if (!g) begin
        m_busy  = 1'b1;
        m_total = 0;
      end
    end else if (a == 8'd0) begin
      m_busy = 1'b0;
    end else begin
      m_total = (m_total + int'(a)) % 256;
    end
  endtask

  task automatic test_reset();
    logic ed;
    logic [7:0] es;
    for (int i = 0; i < 5; i++) begin
      drive((i >= 2), 1'b1, 8'($urandom_range(0, 255)), ed, es);
      vectors++;
      if (done !== 1'b0) begin
        $display("FAIL reset_done cyc%0d: done=%0b expected 0", i, done);
        miscompares++;
      end
      if (i >= 1) begin
        vectors++;
        if (sum !== 8'd0) begin
          $display("FAIL reset_sum cyc%0d: sum=%0d expected 0", i, sum);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_basic();
    logic ed;
    logic [7:0] es;
    logic       g_t[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] a_t[5] = '{8'd4, 8'd4, 8'd4, 8'd0, 8'd7};
    logic       d_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] s_t[5] = '{8'd0, 8'd0, 8'd4, 8'd8, 8'd8};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, g_t[i], a_t[i], ed, es);
      vectors++;
      if (done !== d_t[i] || done !== ed) begin
        $display("FAIL basic_done cyc%0d: done=%0b expected %0b", i, done, d_t[i]);
        miscompares++;
      end
      if (i >= 1) begin
        vectors++;
        if (sum !== s_t[i] || sum !== es) begin
          $display("FAIL basic_sum cyc%0d: sum=%0d expected %0d", i, sum, s_t[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ed;
    logic [7:0] es;
    logic       g_t[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] a_t[7] = '{8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0};
    logic       d_t[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] s_t[7] = '{8'd8, 8'd8, 8'd0, 8'd3, 8'd6, 8'd9, 8'd9};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, g_t[i], a_t[i], ed, es);
      vectors += 2;
      if (done !== d_t[i] || done !== ed) begin
        $display("FAIL b2b_done cyc%0d: done=%0b expected %0b", i, done, d_t[i]);
        miscompares++;
      end
      if (sum !== s_t[i] || sum !== es) begin
        $display("FAIL b2b_sum cyc%0d: sum=%0d expected %0d", i, sum, s_t[i]);
        miscompares++;
      end
    end
    vectors++;
    if (cap_q !== 8'd9) begin
      $display("FAIL b2b_capture: captured=%0d expected 9", cap_q);
      miscompares++;
    end
  endtask

  task automatic test_immediate_zero();
    logic ed;
    logic [7:0] es;
    drive(1'b1, 1'b0, 8'd5, ed, es);
    drive(1'b1, 1'b1, 8'd0, ed, es);
    vectors += 2;
    if (done !== 1'b1 || ed !== 1'b1) begin
      $display("FAIL imm_zero_done: done=%0b expected 1", done);
      miscompares++;
    end
    if (sum !== 8'd0) begin
      $display("FAIL imm_zero_sum: sum=%0d expected 0", sum);
      miscompares++;
    end
  endtask

  task automatic test_wrap_ignored_go();
    logic ed;
    logic [7:0] es;
    logic       g_t[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] a_t[7] = '{8'd9, 8'd200, 8'd100, 8'd0, 8'd0, 8'd6, 8'd0};
    logic       d_t[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] s_t[7] = '{8'd0, 8'd0, 8'd200, 8'd44, 8'd44, 8'd0, 8'd6};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, g_t[i], a_t[i], ed, es);
      vectors += 2;
      if (done !== d_t[i] || done !== ed) begin
        $display("FAIL wrap_done cyc%0d: done=%0b expected %0b", i, done, d_t[i]);
        miscompares++;
      end
      if (sum !== s_t[i] || sum !== es) begin
        $display("FAIL wrap_sum cyc%0d: sum=%0d expected %0d", i, sum, s_t[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ed;
    logic [7:0] es;
    logic       r_t[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       g_t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] a_t[6] = '{8'd1, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0};
    logic [7:0] s_t[6] = '{8'd6, 8'd0, 8'd5, 8'd10, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      drive(r_t[i], g_t[i], a_t[i], ed, es);
      vectors += 2;
      if (done !== 1'b0 || ed !== 1'b0) begin
        $display("FAIL rstmid_done cyc%0d: done=%0b expected 0", i, done);
        miscompares++;
      end
      if (sum !== s_t[i] || sum !== es) begin
        $display("FAIL rstmid_sum cyc%0d: sum=%0d expected %0d", i, sum, s_t[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_random();
    logic ed;
    logic [7:0] es;
    logic r, g;
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) != 0);
      g = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      drive(r, g, a, ed, es);
      vectors += 2;
      if (done !== ed) begin
        $display("FAIL rand_done cyc%0d: done=%0b expected %0b", i, done, ed);
        miscompares++;
      end
      if (sum !== es) begin
        $display("FAIL rand_sum cyc%0d: sum=%0d expected %0d", i, sum, es);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_immediate_zero();
    test_wrap_ignored_go();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
